tx_sched_arb: RTL and testbench



---
 rtl/tx_sched_arb.sv | 133 +++++++++++++
 tb/tb_tx_sched_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sched_arb.sv
// rtl/tx_sched_arb.sv - weighted round-robin packet scheduler in front of the CDP transmit interface
//
// Picks whole packets from a control queue (source 0) and a data queue with a
// per-packet rule queue (source 1). For each grant it writes one rule word to
// the CDP, waits for cdp2um_tx_enable, then streams the packet. Each output word
// is re-framed to 101 (first), 100 (body) or 110 (tail).
//
// Optional build macro TX_STRICT_PRIO_EN: control always wins when it requests.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   mode                    1 = control source disabled
//   ctl_empty/ctl_q/ctl_rdreq       control queue (show-ahead)
//   data_empty/data_q/data_rdreq    data queue (show-ahead)
//   rule_empty/rule_q/rule_rdreq    per-data-packet output port queue
//   cdp2um_rule_usedw       CDP rule FIFO fill, gates new grants
//   cdp2um_tx_enable        CDP ready to take the packet body
//   um2cdp_rule_wrreq/um2cdp_rule   rule write to CDP
//   um2cdp_data_valid/um2cdp_data   packet words to CDP
//   grant_src               source of the current or last grant
module tx_sched_arb #(
  parameter int         W_CTL       = 1,
  parameter int         W_DATA      = 4,
  parameter int         RULE_THRESH = 29,
  parameter logic [7:0] CTL_PORT    = 8'h01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  input  logic         ctl_empty,
  input  logic [138:0] ctl_q,
  output logic         ctl_rdreq,
  input  logic         data_empty,
  input  logic [138:0] data_q,
  output logic         data_rdreq,
  input  logic         rule_empty,
  input  logic [7:0]   rule_q,
  output logic         rule_rdreq,
  input  logic [4:0]   cdp2um_rule_usedw,
  input  logic         cdp2um_tx_enable,
  output logic         um2cdp_rule_wrreq,
  output logic [29:0]  um2cdp_rule,
  output logic         um2cdp_data_valid,
  output logic [138:0] um2cdp_data,
  output logic         grant_src
);

  localparam logic [3:0] WC     = 4'(W_CTL);
  localparam logic [3:0] WD     = 4'(W_DATA);
  localparam logic [5:0] THRESH = 6'(RULE_THRESH);

  typedef enum logic [1:0] {IDLE, RULE, WAIT_EN, XFER} state_t;

  state_t       state, state_nxt;
  logic         last_src;     // also the winner of the packet in flight
  logic [3:0]   grant_cnt;
  logic         first_word;
  logic         req0, req1, credit, win_nxt, pop;
  logic [138:0] head_q;
  logic [2:0]   hdr;

  assign req0   = !ctl_empty && !mode;
  assign req1   = !data_empty && !rule_empty;
  assign credit = {1'b0, cdp2um_rule_usedw} < THRESH;
  assign head_q = last_src ? data_q : ctl_q;

  // Winner for the next grant; only consulted when at least one source requests.
  always_comb begin
    win_nxt = last_src;
`ifdef TX_STRICT_PRIO_EN
    win_nxt = !req0;
`else
    if (req0 && req1)
      win_nxt = (grant_cnt < (last_src ? WD : WC)) ? last_src : !last_src;
    else
      win_nxt = !req0;
`endif
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if ((req0 || req1) && credit) state_nxt = RULE;
      RULE:    state_nxt = WAIT_EN;
      WAIT_EN: if (cdp2um_tx_enable) state_nxt = XFER;
      XFER: begin
        // Gate with reset so an aborted packet loses no word from the queue.
        pop = !(last_src ? data_empty : ctl_empty) && !reset;
        if (pop && head_q[138:136] == 3'b110) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tail passes through; otherwise the framing depends only on position.
  assign hdr = (head_q[138:136] == 3'b110) ? 3'b110 :
               first_word                  ? 3'b101 : 3'b100;

  assign ctl_rdreq         = pop && !last_src;
  assign data_rdreq        = pop && last_src;
  assign rule_rdreq        = (state == RULE) && last_src && !reset;
  assign um2cdp_rule_wrreq = (state == RULE);
  assign um2cdp_rule       = (state == RULE) ? {22'b0, (last_src ? rule_q : CTL_PORT)} : 30'b0;
  assign grant_src         = last_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      last_src          <= 1'b1;
      grant_cnt         <= WD;
      first_word        <= 1'b0;
      um2cdp_data_valid <= 1'b0;
      um2cdp_data       <= '0;
    end else begin
      state             <= state_nxt;
      um2cdp_data_valid <= pop;
      if (pop) begin
        um2cdp_data <= {hdr, head_q[135:0]};
        first_word  <= 1'b0;
      end
      if (state == IDLE && state_nxt == RULE) begin
        last_src   <= win_nxt;
        first_word <= 1'b1;
        if (win_nxt == last_src)
          grant_cnt <= (grant_cnt == 4'd15) ? 4'd15 : grant_cnt + 4'd1;
        else
          grant_cnt <= 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_sched_arb.sv
// tb/tb_tx_sched_arb.sv - directed self-checking bench for tx_sched_arb
module tb_tx_sched_arb;

  logic         clk = 1'b0;
  logic         reset, mode, ctl_empty, data_empty, rule_empty, cdp2um_tx_enable;
  logic [138:0] ctl_q, data_q, um2cdp_data;
  logic [7:0]   rule_q;
  logic [4:0]   cdp2um_rule_usedw;
  logic         ctl_rdreq, data_rdreq, rule_rdreq, um2cdp_rule_wrreq, um2cdp_data_valid, grant_src;
  logic [29:0]  um2cdp_rule;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tx_sched_arb dut (
    .clk(clk), .reset(reset), .mode(mode),
    .ctl_empty(ctl_empty), .ctl_q(ctl_q), .ctl_rdreq(ctl_rdreq),
    .data_empty(data_empty), .data_q(data_q), .data_rdreq(data_rdreq),
    .rule_empty(rule_empty), .rule_q(rule_q), .rule_rdreq(rule_rdreq),
    .cdp2um_rule_usedw(cdp2um_rule_usedw), .cdp2um_tx_enable(cdp2um_tx_enable),
    .um2cdp_rule_wrreq(um2cdp_rule_wrreq), .um2cdp_rule(um2cdp_rule),
    .um2cdp_data_valid(um2cdp_data_valid), .um2cdp_data(um2cdp_data),
    .grant_src(grant_src)
  );

  // Show-ahead queue models
  logic [138:0] cmem [0:255];
  logic [138:0] dmem [0:255];
  logic [7:0]   rmem [0:255];
  int c_rd = 0, c_wr = 0, d_rd = 0, d_wr = 0, r_rd = 0, r_wr = 0;
  logic d_stall = 1'b0;

  assign ctl_empty  = (c_rd == c_wr);
  assign data_empty = (d_rd == d_wr) || d_stall;
  assign rule_empty = (r_rd == r_wr);
  assign ctl_q      = cmem[c_rd & 255];
  assign data_q     = dmem[d_rd & 255];
  assign rule_q     = rmem[r_rd & 255];

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctl_rdreq)  c_rd <= c_rd + 1;
    if (data_rdreq) d_rd <= d_rd + 1;
    if (rule_rdreq) r_rd <= r_rd + 1;
  end

  // Output monitor
  logic [29:0]  rule_log [0:255];
  int           rule_cyc [0:255];
  logic [138:0] dat_log  [0:255];
  int           dat_cyc  [0:255];
  int nr = 0, nd = 0, n_cpop = 0, n_dpop = 0, n_rpop = 0, n_overlap = 0;

  always @(negedge clk) begin
    if (um2cdp_rule_wrreq) begin rule_log[nr & 255] = um2cdp_rule; rule_cyc[nr & 255] = cyc; nr++; end
    if (um2cdp_data_valid) begin dat_log[nd & 255] = um2cdp_data; dat_cyc[nd & 255] = cyc; nd++; end
    if (ctl_rdreq)  n_cpop++;
    if (data_rdreq) n_dpop++;
    if (rule_rdreq) n_rpop++;
    if (um2cdp_rule_wrreq && um2cdp_data_valid) n_overlap++;
  end

  function automatic logic [138:0] wd(input logic [2:0] h, input int tag);
    return {h, 120'h0, tag[15:0]};
  endfunction

  task automatic push_ctl(input logic [2:0] h, input int tag);
    cmem[c_wr & 255] = wd(h, tag); c_wr++;
  endtask
  task automatic push_data(input logic [2:0] h, input int tag);
    dmem[d_wr & 255] = wd(h, tag); d_wr++;
  endtask
  task automatic push_rule(input logic [7:0] p);
    rmem[r_wr & 255] = p; r_wr++;
  endtask
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; cdp2um_rule_usedw = 5'd0; cdp2um_tx_enable = 1'b1;
    step(2);
    n_cmp++; if (ctl_rdreq !== 1'b0) begin n_bad++; $display("FAIL reset_ctl_rdreq got %b exp 0", ctl_rdreq); end
    n_cmp++; if (data_rdreq !== 1'b0) begin n_bad++; $display("FAIL reset_data_rdreq got %b exp 0", data_rdreq); end
    n_cmp++; if (rule_rdreq !== 1'b0) begin n_bad++; $display("FAIL reset_rule_rdreq got %b exp 0", rule_rdreq); end
    n_cmp++; if (um2cdp_rule_wrreq !== 1'b0) begin n_bad++; $display("FAIL reset_wrreq got %b exp 0", um2cdp_rule_wrreq); end
    n_cmp++; if (um2cdp_rule !== 30'h0) begin n_bad++; $display("FAIL reset_rule got %h exp 0", um2cdp_rule); end
    n_cmp++; if (um2cdp_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", um2cdp_data_valid); end
    n_cmp++; if (um2cdp_data !== 139'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", um2cdp_data); end
    n_cmp++; if (grant_src !== 1'b1) begin n_bad++; $display("FAIL reset_grant_src got %b exp 1", grant_src); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_ctl_only();
    int rb, db, cb;
    rb = nr; db = nd; cb = n_cpop;
    push_ctl(3'b101, 1); push_ctl(3'b100, 2); push_ctl(3'b110, 3);
    step(15);
    n_cmp++; if (nr - rb !== 1) begin n_bad++; $display("FAIL ctl_rule_count got %0d exp 1", nr - rb); end
    n_cmp++; if (rule_log[rb] !== 30'h01) begin n_bad++; $display("FAIL ctl_rule got %h exp 01", rule_log[rb]); end
    n_cmp++; if (nd - db !== 3) begin n_bad++; $display("FAIL ctl_word_count got %0d exp 3", nd - db); end
    n_cmp++; if (dat_log[db] !== wd(3'b101, 1)) begin n_bad++; $display("FAIL ctl_w0 got %h exp %h", dat_log[db], wd(3'b101, 1)); end
    n_cmp++; if (dat_log[db+1] !== wd(3'b100, 2)) begin n_bad++; $display("FAIL ctl_w1 got %h exp %h", dat_log[db+1], wd(3'b100, 2)); end
    n_cmp++; if (dat_log[db+2] !== wd(3'b110, 3)) begin n_bad++; $display("FAIL ctl_w2 got %h exp %h", dat_log[db+2], wd(3'b110, 3)); end
    n_cmp++; if (n_cpop - cb !== 3) begin n_bad++; $display("FAIL ctl_pops got %0d exp 3", n_cpop - cb); end
    n_cmp++; if (dat_cyc[db] - rule_cyc[rb] !== 3) begin n_bad++; $display("FAIL ctl_rule_to_data got %0d exp 3", dat_cyc[db] - rule_cyc[rb]); end
    n_cmp++; if (dat_cyc[db+2] - dat_cyc[db] !== 2) begin n_bad++; $display("FAIL ctl_burst_span got %0d exp 2", dat_cyc[db+2] - dat_cyc[db]); end
  endtask

  task automatic test_wrr();
    logic [19:0] exp_src;
    logic [29:0] exp_rule;
    int rb, db, cb, dpb, rpb, di;
    // grant order c,d,d,d,d,c,d,d,d,d,c,d,d, then the remaining seven control packets
    exp_src = 20'b0000000_1101111011110;
    rb = nr; db = nd; cb = n_cpop; dpb = n_dpop; rpb = n_rpop;
    for (int i = 0; i < 10; i++) begin
      push_ctl(3'b110, 100 + i);
      push_data(3'b100, 200 + 2*i); push_data(3'b110, 201 + 2*i);
      push_rule(8'h10 + 8'(i));
    end
    reset = 1'b1; step(1); reset = 1'b0;
    step(130);
    n_cmp++; if (nr - rb !== 20) begin n_bad++; $display("FAIL wrr_rule_count got %0d exp 20", nr - rb); end
    di = 0;
    for (int k = 0; k < 20; k++) begin
      if (exp_src[k]) begin exp_rule = 30'h10 + 30'(di); di++; end
      else exp_rule = 30'h01;
      n_cmp++;
      if (rule_log[rb+k] !== exp_rule) begin n_bad++; $display("FAIL wrr_grant_%0d got %h exp %h", k, rule_log[rb+k], exp_rule); end
    end
    n_cmp++; if (n_rpop - rpb !== 10) begin n_bad++; $display("FAIL wrr_rule_pops got %0d exp 10", n_rpop - rpb); end
    n_cmp++; if (n_cpop - cb !== 10) begin n_bad++; $display("FAIL wrr_ctl_pops got %0d exp 10", n_cpop - cb); end
    n_cmp++; if (n_dpop - dpb !== 20) begin n_bad++; $display("FAIL wrr_data_pops got %0d exp 20", n_dpop - dpb); end
    n_cmp++; if (nd - db !== 30) begin n_bad++; $display("FAIL wrr_words got %0d exp 30", nd - db); end
  endtask

  task automatic test_credit();
    int rb, db;
    rb = nr; db = nd;
    cdp2um_rule_usedw = 5'd29;
    push_ctl(3'b110, 300);
    step(8);
    n_cmp++; if (nr !== rb) begin n_bad++; $display("FAIL credit_blocked got %0d rules exp 0", nr - rb); end
    n_cmp++; if (ctl_rdreq !== 1'b0) begin n_bad++; $display("FAIL credit_rdreq got %b exp 0", ctl_rdreq); end
    cdp2um_rule_usedw = 5'd28;
    step(1);
    n_cmp++; if (um2cdp_rule_wrreq !== 1'b1) begin n_bad++; $display("FAIL credit_wrreq got %b exp 1", um2cdp_rule_wrreq); end
    n_cmp++; if (um2cdp_rule !== 30'h01) begin n_bad++; $display("FAIL credit_rule got %h exp 01", um2cdp_rule); end
    step(6);
    cdp2um_rule_usedw = 5'd0;
    n_cmp++; if (nd - db !== 1) begin n_bad++; $display("FAIL credit_words got %0d exp 1", nd - db); end
    n_cmp++; if (dat_log[db] !== wd(3'b110, 300)) begin n_bad++; $display("FAIL credit_word got %h exp %h", dat_log[db], wd(3'b110, 300)); end
  endtask

  task automatic test_stall();
    logic [14:0] hdrs;
    int rb, db, dpb;
    hdrs = {3'b110, 3'b100, 3'b100, 3'b100, 3'b101};
    rb = nr; db = nd; dpb = n_dpop;
    push_data(3'b100, 400); push_data(3'b100, 401); push_data(3'b100, 402);
    push_data(3'b100, 403); push_data(3'b110, 404); push_rule(8'h5A);
    for (int i = 0; i < 20 && (n_dpop - dpb) < 2; i++) step(1);
    n_cmp++; if (n_dpop - dpb !== 2) begin n_bad++; $display("FAIL stall_reach_word2 got %0d exp 2", n_dpop - dpb); end
    d_stall = 1'b1;
    push_ctl(3'b110, 500);
    step(4);
    n_cmp++; if (grant_src !== 1'b1) begin n_bad++; $display("FAIL stall_grant_src got %b exp 1", grant_src); end
    n_cmp++; if (ctl_rdreq !== 1'b0) begin n_bad++; $display("FAIL stall_ctl_rdreq got %b exp 0", ctl_rdreq); end
    d_stall = 1'b0;
    step(20);
    n_cmp++; if (nr - rb !== 2) begin n_bad++; $display("FAIL stall_rule_count got %0d exp 2", nr - rb); end
    n_cmp++; if (rule_log[rb] !== 30'h5A) begin n_bad++; $display("FAIL stall_rule0 got %h exp 5a", rule_log[rb]); end
    n_cmp++; if (rule_log[rb+1] !== 30'h01) begin n_bad++; $display("FAIL stall_rule1 got %h exp 01", rule_log[rb+1]); end
    n_cmp++; if (nd - db !== 6) begin n_bad++; $display("FAIL stall_words got %0d exp 6", nd - db); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dat_log[db+i] !== wd(hdrs[3*i +: 3], 400 + i)) begin n_bad++; $display("FAIL stall_w%0d got %h exp %h", i, dat_log[db+i], wd(hdrs[3*i +: 3], 400 + i)); end
    end
    n_cmp++; if (dat_cyc[db+2] - dat_cyc[db+1] !== 5) begin n_bad++; $display("FAIL stall_gap got %0d exp 5", dat_cyc[db+2] - dat_cyc[db+1]); end
    n_cmp++; if (dat_log[db+5] !== wd(3'b110, 500)) begin n_bad++; $display("FAIL stall_next_ctl got %h exp %h", dat_log[db+5], wd(3'b110, 500)); end
  endtask

  task automatic test_mode();
    int rb, cb;
    rb = nr; cb = n_cpop;
    mode = 1'b1;
    push_ctl(3'b110, 600); push_ctl(3'b110, 601);
    push_data(3'b100, 700); push_data(3'b110, 701); push_rule(8'h21);
    push_data(3'b100, 702); push_data(3'b110, 703); push_rule(8'h22);
    step(25);
    n_cmp++; if (n_cpop - cb !== 0) begin n_bad++; $display("FAIL mode_ctl_pops got %0d exp 0", n_cpop - cb); end
    n_cmp++; if (nr - rb !== 2) begin n_bad++; $display("FAIL mode_rule_count got %0d exp 2", nr - rb); end
    n_cmp++; if (rule_log[rb] !== 30'h21) begin n_bad++; $display("FAIL mode_rule0 got %h exp 21", rule_log[rb]); end
    n_cmp++; if (rule_log[rb+1] !== 30'h22) begin n_bad++; $display("FAIL mode_rule1 got %h exp 22", rule_log[rb+1]); end
    mode = 1'b0;
    step(15);
    n_cmp++; if (n_cpop - cb !== 2) begin n_bad++; $display("FAIL mode_ctl_drain got %0d exp 2", n_cpop - cb); end
    n_cmp++; if (nr - rb !== 4) begin n_bad++; $display("FAIL mode_total_rules got %0d exp 4", nr - rb); end
  endtask

  task automatic test_reset_mid();
    int rb, db;
    db = nd;
    push_ctl(3'b101, 800); push_ctl(3'b100, 801); push_ctl(3'b100, 802); push_ctl(3'b110, 803);
    for (int i = 0; i < 20 && (nd - db) < 1; i++) step(1);
    n_cmp++; if (nd - db !== 1) begin n_bad++; $display("FAIL rstmid_reach_xfer got %0d exp 1", nd - db); end
    reset = 1'b1;
    #1;
    n_cmp++; if (ctl_rdreq !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdreq_same_cycle got %b exp 0", ctl_rdreq); end
    push_data(3'b100, 900); push_data(3'b110, 901); push_rule(8'h33);
    step(1);
    n_cmp++; if (um2cdp_data_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b exp 0", um2cdp_data_valid); end
    n_cmp++; if (um2cdp_data !== 139'h0) begin n_bad++; $display("FAIL rstmid_data got %h exp 0", um2cdp_data); end
    n_cmp++; if (um2cdp_rule_wrreq !== 1'b0) begin n_bad++; $display("FAIL rstmid_wrreq got %b exp 0", um2cdp_rule_wrreq); end
    n_cmp++; if ({ctl_rdreq, data_rdreq, rule_rdreq} !== 3'b000) begin n_bad++; $display("FAIL rstmid_rdreqs got %b exp 000", {ctl_rdreq, data_rdreq, rule_rdreq}); end
    n_cmp++; if (grant_src !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant_src got %b exp 1", grant_src); end
    reset = 1'b0;
    rb = nr; db = nd;
    step(20);
    n_cmp++; if (rule_log[rb] !== 30'h01) begin n_bad++; $display("FAIL rstmid_first_tie got %h exp 01", rule_log[rb]); end
    n_cmp++; if (rule_log[rb+1] !== 30'h33) begin n_bad++; $display("FAIL rstmid_second got %h exp 33", rule_log[rb+1]); end
    n_cmp++; if (dat_log[db] !== wd(3'b101, 802)) begin n_bad++; $display("FAIL rstmid_w0 got %h exp %h", dat_log[db], wd(3'b101, 802)); end
    n_cmp++; if (dat_log[db+1] !== wd(3'b110, 803)) begin n_bad++; $display("FAIL rstmid_w1 got %h exp %h", dat_log[db+1], wd(3'b110, 803)); end
    n_cmp++; if (n_overlap !== 0) begin n_bad++; $display("FAIL overlap got %0d exp 0", n_overlap); end
  endtask

  initial begin
    test_reset();
    test_ctl_only();
    test_wrr();
    test_credit();
    test_stall();
    test_mode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
